mux3_1_checked: RTL and testbench
=================================

// Module: mux3_1_checked
// PURPOSE
//  Registered 3:1 multiplexer built from two independent selection datapaths.
//  Path A is continuous-assign style; path B is procedural (always/case) style.
//  Path A drives the output. Path B runs in lockstep as a self-check and sets a sticky mismatch flag.
//  Sits in datapath select logic wherever one of three sources feeds a pipeline stage.
// PARAMETERS
//  WIDTH      1   data width of D0/D1/D2/Y (>=1)
//  REG_OUT    1   1: Y registered (1-cycle latency); 0: Y combinational
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  D0         in   WIDTH  data input 0
//  D1         in   WIDTH  data input 1
//  D2         in   WIDTH  data input 2
//  S0         in   1      select bit 0 (LSB)
//  S1         in   1      select bit 1 (MSB)
//  Y          out  WIDTH  selected data (path A)
//  Y_comb     out  WIDTH  combinational path A result, always 0-latency
//  mismatch   out  1      sticky: path A != path B seen at a clock edge
// BEHAVIOUR
//  - Select map, {S1,S0}: 00->D0, 01->D1, 10->D2, 11->D2 (S1 dominates).
//  - Path A: Y_comb = S1 ? D2 : (S0 ? D1 : D0), pure combinational.
//  - Path B: always @* case({S1,S0}) giving the identical map; default branch = D2, no latches.
//  - REG_OUT=1: Y <= Y_comb on each rising clk edge; select-to-Y latency is 1 cycle.
//  - REG_OUT=0: Y = Y_comb; clk/rst_n affect only the checker.
//  - Reset (rst_n=0, async, no clock needed): Y=0 (when REG_OUT=1), mismatch=0.
//  - Y_comb is not reset and follows inputs even while rst_n=0.
//  - Release of rst_n is synchronous to the next rising edge.
//  - First capture happens on the first rising edge with rst_n=1.
//  - Checker: on each rising edge with rst_n=1, compares A and B bitwise.
//    Any difference sets mismatch=1, which holds until rst_n=0.
//  - X/Z on a select: no requirement on Y. Checker compares with !== so X divergence is flagged.
//  - Simultaneous input and select change: Y reflects the values present at the capturing edge.
//  - Reset asserted mid-operation: Y and mismatch clear immediately.
//    The pending capture is discarded.
// TESTING
//  1 Reset: rst_n=0, D0=1,D1=0,D2=0,S=00 -> Y=0, mismatch=0 immediately; after release + 1 edge Y=1.
//  2 Exhaustive, WIDTH=1: all 32 combos of D0,D1,D2,S0,S1, one per cycle.
//    Y one cycle later = D0/D1/D2/D2 per select; mismatch stays 0.
//  3 Priority: D0=0,D1=0,D2=1, {S1,S0}=11 -> Y=1.
//    Then D2=0,D1=1, S=11 -> Y=0 (D1 ignored).
//  4 WIDTH=8 random: 99 cycles of $random D0..D2/S0/S1.
//    Y == Y_comb delayed one cycle; Y_comb == reference model every cycle; mismatch=0.
//  5 Async reset mid-stream: rst_n pulled low between edges while Y=8'hA5 -> Y=8'h00 with no clock edge.
//  6 REG_OUT=0: S=01, D1=8'h3C -> Y=8'h3C within the same delta (no clock).

Source files
------------

// File: rtl/mux3_1_checked.sv
// mux3_1_checked
//   Registered 3:1 multiplexer with a built-in redundant self-check.
//   Two independently written selection paths compute the same result:
//     path A - continuous assignment, drives Y_comb and (optionally
//              registered) Y
//     path B - procedural case statement, used only by the checker
//   On every rising clk edge with rst_n high the two paths are compared
//   bitwise. Any disagreement sets the sticky mismatch flag, which only
//   reset clears.
//
//   Select map {S1,S0}: 00->D0, 01->D1, 10->D2, 11->D2 (S1 dominates).
//
// Parameters
//   WIDTH    data width of D0/D1/D2/Y/Y_comb (>= 1)
//   REG_OUT  1: Y registered (1-cycle latency), 0: Y = Y_comb
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears Y and mismatch)
//   D0/D1/D2  data inputs
//   S0, S1    select bits (S1 is the MSB)
//   Y         selected data from path A
//   Y_comb    combinational path A result, never reset
//   mismatch  sticky flag: path A differed from path B at a clock edge
module mux3_1_checked #(
   parameter int unsigned WIDTH   = 1,
   parameter bit          REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic [WIDTH-1:0] D2,
   input  logic             S0,
   input  logic             S1,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_comb,
   output logic             mismatch
);

   logic [WIDTH-1:0] path_a;
   logic [WIDTH-1:0] path_b;
   logic [1:0]       sel;

   assign sel = {S1, S0};

   // Path A: nested conditional, S1 checked first so it dominates.
   assign path_a = S1 ? D2 : (S0 ? D1 : D0);
   assign Y_comb = path_a;

   // Path B: written as a case so it shares no structure with path A.
   // The default arm covers 2'b1x and keeps the block latch-free.
   always_comb begin
      path_b = D2;
      case (sel)
         2'b00:   path_b = D0;
         2'b01:   path_b = D1;
         default: path_b = D2;
      endcase
   end

   // Output stage. Reset only matters for the registered form; in the
   // combinational form clk/rst_n reach the checker alone.
   generate
      if (REG_OUT) begin : g_reg_out
         logic [WIDTH-1:0] y_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               y_q <= '0;
            end else begin
               y_q <= path_a;
            end
         end

         assign Y = y_q;
      end else begin : g_comb_out
         assign Y = path_a;
      end
   endgenerate

   // Sticky checker. Case inequality is used so that an X on one path
   // but not the other still counts as a divergence in simulation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch <= 1'b0;
      end else if (path_a !== path_b) begin
         mismatch <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux3_1_checked.sv
module tb_mux3_1_checked;

   typedef struct {
      logic       d0;
      logic       d1;
      logic       d2;
      logic [1:0] sel;
      logic       exp_y;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   // WIDTH=1, registered
   logic       a_d0, a_d1, a_d2, a_s0, a_s1;
   logic       a_y, a_yc, a_mm;
   // WIDTH=8, registered
   logic [7:0] b_d0, b_d1, b_d2;
   logic       b_s0, b_s1;
   logic [7:0] b_y, b_yc;
   logic       b_mm;
   // WIDTH=8, combinational output
   logic [7:0] c_d0, c_d1, c_d2;
   logic       c_s0, c_s1;
   logic [7:0] c_y, c_yc;
   logic       c_mm;

   int tests = 0;
   int failed = 0;

   vec_t vecs [34];

   always #5 clk = ~clk;

   mux3_1_checked #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .D0(a_d0), .D1(a_d1), .D2(a_d2),
      .S0(a_s0), .S1(a_s1), .Y(a_y), .Y_comb(a_yc), .mismatch(a_mm)
   );

   mux3_1_checked #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
      .clk(clk), .rst_n(rst_n), .D0(b_d0), .D1(b_d1), .D2(b_d2),
      .S0(b_s0), .S1(b_s1), .Y(b_y), .Y_comb(b_yc), .mismatch(b_mm)
   );

   mux3_1_checked #(.WIDTH(8), .REG_OUT(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .D0(c_d0), .D1(c_d1), .D2(c_d2),
      .S0(c_s0), .S1(c_s1), .Y(c_y), .Y_comb(c_yc), .mismatch(c_mm)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_mux(input logic [7:0] d0, input logic [7:0] d1,
                                          input logic [7:0] d2, input logic [1:0] sel);
      logic [7:0] r;
      if (sel == 2'b00)      r = d0;
      else if (sel == 2'b01) r = d1;
      else                   r = d2;
      return r;
   endfunction

   initial begin
      logic [7:0] exp_prev;
      logic [1:0] rs;

      // Exhaustive table: index bits {S1,S0,D2,D1,D0}.
      for (int i = 0; i < 32; i++) begin
         logic [4:0] b;
         b = 5'(i);
         vecs[i].d0    = b[0];
         vecs[i].d1    = b[1];
         vecs[i].d2    = b[2];
         vecs[i].sel   = b[4:3];
         vecs[i].exp_y = b[4] ? b[2] : (b[3] ? b[1] : b[0]);
      end
      // S1 dominance, hand-computed.
      vecs[32] = '{d0: 1'b0, d1: 1'b0, d2: 1'b1, sel: 2'b11, exp_y: 1'b1};
      vecs[33] = '{d0: 1'b0, d1: 1'b1, d2: 1'b0, sel: 2'b11, exp_y: 1'b0};

      a_d0 = 1'b1; a_d1 = 1'b0; a_d2 = 1'b0; a_s0 = 1'b0; a_s1 = 1'b0;
      b_d0 = 8'h00; b_d1 = 8'h00; b_d2 = 8'h00; b_s0 = 1'b0; b_s1 = 1'b0;
      c_d0 = 8'h00; c_d1 = 8'h00; c_d2 = 8'h00; c_s0 = 1'b0; c_s1 = 1'b0;

      // Reset state, before any clock edge.
      #2;
      chk("rst_y_w1", 8'(a_y), 8'h00);
      chk("rst_mm_w1", 8'(a_mm), 8'h00);
      chk("rst_y_w8", b_y, 8'h00);
      chk("rst_yc_w1_follows", 8'(a_yc), 8'h01);

      // Reset held across an edge: still cleared.
      @(posedge clk); #1;
      chk("rst_hold_y_w1", 8'(a_y), 8'h00);

      // Release, first capture on the next edge.
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_y_w1", 8'(a_y), 8'h01);

      // Exhaustive + priority on WIDTH=1.
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         a_d0 = vecs[i].d0; a_d1 = vecs[i].d1; a_d2 = vecs[i].d2;
         a_s0 = vecs[i].sel[0]; a_s1 = vecs[i].sel[1];
         #1;
         chk($sformatf("vec%0d_yc", i), 8'(a_yc), 8'(vecs[i].exp_y));
         @(posedge clk); #1;
         chk($sformatf("vec%0d_y", i), 8'(a_y), 8'(vecs[i].exp_y));
      end
      chk("w1_mismatch_clear", 8'(a_mm), 8'h00);

      // Random WIDTH=8, Y checked as Y_comb delayed one cycle.
      exp_prev = b_yc;
      for (int i = 0; i < 99; i++) begin
         @(negedge clk);
         b_d0 = 8'($urandom); b_d1 = 8'($urandom); b_d2 = 8'($urandom);
         rs = 2'($urandom);
         b_s0 = rs[0]; b_s1 = rs[1];
         #1;
         chk($sformatf("rnd%0d_yc", i), b_yc, ref_mux(b_d0, b_d1, b_d2, rs));
         exp_prev = ref_mux(b_d0, b_d1, b_d2, rs);
         @(posedge clk); #1;
         chk($sformatf("rnd%0d_y", i), b_y, exp_prev);
      end
      chk("w8_mismatch_clear", 8'(b_mm), 8'h00);

      // Async reset mid-stream, between edges.
      @(negedge clk);
      b_d0 = 8'hA5; b_s0 = 1'b0; b_s1 = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_y", b_y, 8'hA5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_y", b_y, 8'h00);
      chk("async_rst_mm", 8'(b_mm), 8'h00);
      chk("async_rst_yc", b_yc, 8'hA5);
      @(posedge clk); #1;
      chk("rst_discard_y", b_y, 8'h00);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_y", b_y, 8'hA5);

      // REG_OUT=0: Y follows inputs with no clock edge.
      @(negedge clk);
      c_d0 = 8'h11; c_d1 = 8'h3C; c_d2 = 8'h77;
      c_s0 = 1'b1; c_s1 = 1'b0;
      #1;
      chk("comb_y_sel01", c_y, 8'h3C);
      c_s1 = 1'b1;
      #1;
      chk("comb_y_sel11", c_y, 8'h77);
      c_s0 = 1'b0; c_s1 = 1'b0;
      #1;
      chk("comb_y_sel00", c_y, 8'h11);
      @(posedge clk); #1;
      chk("comb_mismatch_clear", 8'(c_mm), 8'h00);
      chk("final_mm_w1", 8'(a_mm), 8'h00);
      chk("final_mm_w8", 8'(b_mm), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
